// File: rtl/rx_fcs_strip.sv
// Receive-path preamble/SFD stripper with FCS removal and CRC-32 residue check.
// Optional per-verdict statistics counters are built when RX_FCS_STATS_EN is defined.
module rx_fcs_strip #(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic        clk125MHz,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_enable,
    output logic [7:0]  rawdata,
    output logic        raw_en,
    output logic        frame_done,
    output logic        fcs_ok,
    output logic        len_err,
    output logic [10:0] frame_len
`ifdef RX_FCS_STATS_EN
    ,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } state_t;

    localparam logic [10:0] MIN_LEN_C = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_LEN_C = 11'(MAX_FRAME);

    state_t          state_r;
    state_t          state_s;
    logic            sfd_s;
    logic            byte_s;
    logic            end_s;
    logic            runt_s;
    logic            over_s;
    logic            good_s;
    logic [31:0]     crc_r;
    logic [10:0]     count_r;
    logic [2:0]      fill_r;
    logic [3:0][7:0] dline_r;

    // Reflected CRC-32 advanced by one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ 32'hEDB88320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // Frames under five bytes can never emit data and are always length errors.
    assign runt_s = (count_r < MIN_LEN_C) || (count_r < 11'd5);
    assign over_s = (count_r > MAX_LEN_C);
    assign good_s = (crc_r == 32'hDEBB20E3) && !runt_s && !over_s;

    // State register.
    always_ff @(posedge clk125MHz or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        state_s = state_r;
        sfd_s   = 1'b0;
        byte_s  = 1'b0;
        end_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (rx_enable) begin
                    if (rx_data == 8'h55) begin
                        state_s = PREAMBLE;
                    end else begin
                        state_s = DROP;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            PREAMBLE: begin
                if (!rx_enable) begin
                    state_s = IDLE;
                end else if (rx_data == 8'h55) begin
                    state_s = PREAMBLE;
                end else if (rx_data == 8'hD5) begin
                    state_s = DATA;
                    sfd_s   = 1'b1;
                end else begin
                    state_s = DROP;
                end
            end
            DATA: begin
                if (rx_enable) begin
                    byte_s = 1'b1;
                end else begin
                    end_s   = 1'b1;
                    state_s = IDLE;
                end
            end
            DROP: begin
                if (!rx_enable) begin
                    state_s = IDLE;
                end else begin
                    state_s = DROP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // CRC, length count, FCS delay line and registered outputs.
    always_ff @(posedge clk125MHz or negedge resetn) begin
        if (!resetn) begin
            crc_r      <= 32'hFFFFFFFF;
            count_r    <= 11'd0;
            fill_r     <= 3'd0;
            dline_r    <= {4{8'h00}};
            rawdata    <= 8'h00;
            raw_en     <= 1'b0;
            frame_done <= 1'b0;
            fcs_ok     <= 1'b0;
            len_err    <= 1'b0;
            frame_len  <= 11'd0;
        end else begin
            raw_en     <= 1'b0;
            frame_done <= 1'b0;
            if (sfd_s) begin
                crc_r   <= 32'hFFFFFFFF;
                count_r <= 11'd0;
                fill_r  <= 3'd0;
                dline_r <= {4{8'h00}};
            end else if (byte_s) begin
                crc_r   <= crc32_byte(crc_r, rx_data);
                count_r <= (count_r == 11'h7FF) ? count_r : count_r + 11'd1;
                dline_r <= {dline_r[2:0], rx_data};
                // Once four bytes are held, anything older cannot be part of the FCS.
                if (fill_r == 3'd4) begin
                    rawdata <= dline_r[3];
                    raw_en  <= 1'b1;
                end else begin
                    fill_r <= fill_r + 3'd1;
                end
            end else if (end_s) begin
                frame_done <= 1'b1;
                fcs_ok     <= good_s;
                len_err    <= runt_s || over_s;
                frame_len  <= count_r;
            end
        end
    end

`ifdef RX_FCS_STATS_EN
    // Saturating good/bad verdict counters, updated together with frame_done.
    always_ff @(posedge clk125MHz or negedge resetn) begin
        if (!resetn) begin
            good_cnt <= 16'h0000;
            bad_cnt  <= 16'h0000;
        end else if (end_s) begin
            if (good_s) begin
                good_cnt <= (good_cnt == 16'hFFFF) ? good_cnt : good_cnt + 16'h0001;
            end else begin
                bad_cnt <= (bad_cnt == 16'hFFFF) ? bad_cnt : bad_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule
